// File: rtl/hash_msg_pack.sv
// hash_msg_pack: packs a big-endian 32-bit word stream into 64/128-byte SHA-2 blocks.
// Define HASH_PACK_SKID_EN for a second fill buffer that keeps din flowing during hand-off.
module hash_msg_pack (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mode_384,
    input  logic          msg_start,
    input  logic          din_valid,
    output logic          din_ready,
    input  logic [31:0]   din,
    input  logic          din_last,
    input  logic [2:0]    din_nbytes,
    output logic          blk_valid,
    input  logic          blk_ready,
    output logic [1023:0] blk,
    output logic          blk_last,
    output logic [7:0]    blk_nbytes,
    output logic [31:0]   msg_size,
    output logic          ovf_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic           mode;
    logic [1023:0]  fbuf;
    logic [1023:0]  fbuf_nxt;
    logic [7:0]     ptr;
    logic [7:0]     ptr_nxt;
    logic [31:0]    cnt;
    logic [32:0]    cnt_sum;
    logic [31:0]    wmask;
    logic [4:0]     wslot;
    logic           accept;
    logic           complete;

    // msg_start outranks a word that happens to handshake in the same cycle
    assign accept   = din_valid & din_ready & ~msg_start;
    assign ptr_nxt  = ptr + {5'd0, din_nbytes};
    assign cnt_sum  = {1'b0, cnt} + {30'd0, din_nbytes};
    assign complete = din_last | (ptr_nxt == (mode ? 8'd128 : 8'd64));
    assign wslot    = ~ptr[6:2];

    always_comb begin
        unique case (din_nbytes)
            3'd0:    wmask = 32'h0000_0000;
            3'd1:    wmask = 32'hFF00_0000;
            3'd2:    wmask = 32'hFFFF_0000;
            3'd3:    wmask = 32'hFFFF_FF00;
            default: wmask = 32'hFFFF_FFFF;
        endcase
    end

    always_comb begin
        fbuf_nxt = fbuf;
        fbuf_nxt[{wslot, 5'd0} +: 32] = din & wmask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode    <= 1'b0;
            cnt     <= 32'd0;
            ovf_err <= 1'b0;
        end else if (msg_start) begin
            mode    <= mode_384;
            cnt     <= 32'd0;
            ovf_err <= 1'b0;
        end else if (accept) begin
            cnt     <= cnt_sum[31:0];
            ovf_err <= ovf_err | cnt_sum[32];
        end
    end

`ifdef HASH_PACK_SKID_EN

    logic [1023:0]  obuf;
    logic [7:0]     onb;
    logic           olast;
    logic [31:0]    osize;
    logic           flast;
    logic [31:0]    fsize;
    logic           pend;
    logic           done;
    logic           load_new;
    logic           load_fill;
    logic           park;

    // done blocks words after din_last until the next msg_start
    assign din_ready  = (state != IDLE) & ~pend & ~done;
    assign blk_valid  = (state == HOLD);
    assign blk        = obuf;
    assign blk_last   = olast;
    assign blk_nbytes = onb;
    assign msg_size   = osize;

    always_comb begin
        state_nxt = state;
        load_new  = 1'b0;
        load_fill = 1'b0;
        park      = 1'b0;
        unique case (state)
            IDLE: ;
            FILL: begin
                if (accept && complete) begin
                    load_new  = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (blk_ready) begin
                    if (pend) begin
                        load_fill = 1'b1;
                    end else if (accept && complete) begin
                        load_new = 1'b1;
                    end else begin
                        state_nxt = olast ? IDLE : FILL;
                    end
                end else if (accept && complete) begin
                    park = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (msg_start) begin
            state_nxt = FILL;
            load_new  = 1'b0;
            load_fill = 1'b0;
            park      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fbuf  <= '0;
            ptr   <= 8'd0;
            flast <= 1'b0;
            fsize <= 32'd0;
            pend  <= 1'b0;
            done  <= 1'b0;
            obuf  <= '0;
            onb   <= 8'd0;
            olast <= 1'b0;
            osize <= 32'd0;
        end else if (msg_start) begin
            fbuf  <= '0;
            ptr   <= 8'd0;
            flast <= 1'b0;
            fsize <= 32'd0;
            pend  <= 1'b0;
            done  <= 1'b0;
            obuf  <= '0;
            onb   <= 8'd0;
            olast <= 1'b0;
            osize <= 32'd0;
        end else begin
            if (accept && din_last) begin
                done <= 1'b1;
            end
            if (load_new) begin
                obuf  <= fbuf_nxt;
                onb   <= ptr_nxt;
                olast <= din_last;
                osize <= cnt_sum[31:0];
            end else if (load_fill) begin
                obuf  <= fbuf;
                onb   <= ptr;
                olast <= flast;
                osize <= fsize;
            end
            if (load_new || load_fill) begin
                fbuf  <= '0;
                ptr   <= 8'd0;
                flast <= 1'b0;
                pend  <= 1'b0;
            end else if (accept) begin
                fbuf <= fbuf_nxt;
                ptr  <= ptr_nxt;
                if (park) begin
                    pend  <= 1'b1;
                    flast <= din_last;
                    fsize <= cnt_sum[31:0];
                end
            end
        end
    end

`else

    logic           last;
    logic           handoff;

    // The fill buffer doubles as the output register while in HOLD
    assign din_ready  = (state == FILL);
    assign blk_valid  = (state == HOLD);
    assign blk        = fbuf;
    assign blk_last   = last;
    assign blk_nbytes = ptr;
    assign msg_size   = cnt;

    always_comb begin
        state_nxt = state;
        handoff   = 1'b0;
        unique case (state)
            IDLE: ;
            FILL: begin
                if (accept && complete) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (blk_ready) begin
                    handoff   = 1'b1;
                    state_nxt = last ? IDLE : FILL;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (msg_start) begin
            state_nxt = FILL;
            handoff   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fbuf <= '0;
            ptr  <= 8'd0;
            last <= 1'b0;
        end else if (msg_start || handoff) begin
            fbuf <= '0;
            ptr  <= 8'd0;
            last <= 1'b0;
        end else if (accept) begin
            fbuf <= fbuf_nxt;
            ptr  <= ptr_nxt;
            last <= din_last;
        end
    end

`endif

endmodule
